// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer_if
//  Description : Core-side and memory-side signal bundle of the store buffer.
//                The master side is the environment (core plus data_mem):
//                it drives the core requests and the memory read data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Core data port
    logic          cpu_we;
    logic          cpu_re;
    logic [3:0]    cpu_wstrb;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    // data_mem port
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output cpu_we, cpu_re, cpu_wstrb, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, cpu_stall, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_we, cpu_re, cpu_wstrb, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, cpu_stall, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Write buffer between the core data port and data_mem.
//                Stores retire into a DEPTH-entry FIFO and drain to memory
//                in cycles without a load. Loads own the memory port and
//                get per-byte forwarding from the youngest buffered store.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    store_buffer_if.slave                   bus,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            empty,
    output logic                            full
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int WAW = AW - 2;

    // Entry payload: word address, byte strobes, data
    logic [WAW-1:0]   r_addr [DEPTH];
    logic [3:0]       r_strb [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;

    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;
    logic [DW-1:0]    w_rdata;
    logic [3:0]       w_mem_we;
    logic [AW-1:0]    w_mem_addr;
    logic [DW-1:0]    w_mem_wdata;

    // A store is accepted unless the registered full flag is set; a pop in
    // the same cycle does not make room early.
    assign w_push = bus.cpu_we & ~r_full;
    // A load owns the memory port, so draining only happens in load-free cycles.
    assign w_pop  = ~bus.cpu_re & ~r_empty;

    // Occupancy after this edge
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Pointers, occupancy and per-entry valid bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_valid <= '0;
        end else begin
            // Push and pop never target the same slot: that would need the
            // buffer to be both non-empty and non-full with head == tail.
            if (w_pop) begin
                r_head          <= r_head + PW'(1);
                r_valid[r_head] <= 1'b0;
            end
            if (w_push) begin
                r_tail          <= r_tail + PW'(1);
                r_valid[r_tail] <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    // Entry payload capture; qualified by the valid bits, so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= bus.cpu_addr[AW-1:2];
            r_strb[r_tail] <= bus.cpu_wstrb;
            r_data[r_tail] <= bus.cpu_wdata;
        end
    end

    // Load data: walk entries oldest to youngest so the youngest match wins
    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx   = '0;
        w_rdata = bus.mem_rdata;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_head + PW'(k);
            if ((CW'(k) < r_count) && r_valid[v_idx] &&
                (r_addr[v_idx] == bus.cpu_addr[AW-1:2])) begin
                for (int i = 0; i < 4; i++) begin
                    if (r_strb[v_idx][i]) begin
                        w_rdata[8*i +: 8] = r_data[v_idx][8*i +: 8];
                    end
                end
            end
        end
    end

    // Memory port arbitration: load first, then drain the head, else idle
    always_comb begin
        w_mem_addr  = bus.cpu_addr;
        w_mem_we    = 4'b0000;
        w_mem_wdata = '0;
        if (!bus.cpu_re && !r_empty) begin
            w_mem_addr  = {r_addr[r_head], 2'b00};
            w_mem_we    = r_strb[r_head];
            w_mem_wdata = r_data[r_head];
        end
    end

    assign bus.cpu_rdata = w_rdata;
    assign bus.cpu_stall = bus.cpu_we & r_full;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    assign count = r_count;
    assign empty = r_empty;
    assign full  = r_full;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Self-checking bench for store_buffer. The bench plays both
//                the core and data_mem; a queue-based model predicts every
//                output each cycle, and directed literals pin key results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_buffer_if #(.AW(AW), .DW(DW)) bus ();
    logic [2:0] count;
    logic       empty;
    logic       full;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    // data_mem: 64 words, combinational read
    logic [31:0] mem [64];
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  strb;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] wlog[$];

    logic        s_valid = 1'b0;
    logic [3:0]  s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;

    function automatic logic [31:0] exp_load(input logic [31:0] a);
        logic [31:0] r;
        r = mem[a[7:2]];
        foreach (q[k]) begin
            if (q[k].waddr == a[31:2]) begin
                for (int i = 0; i < 4; i++) begin
                    if (q[k].strb[i]) r[8*i +: 8] = q[k].data[8*i +: 8];
                end
            end
        end
        return r;
    endfunction

    // compare every cycle against the model, and sample the memory port
    always @(negedge clk) begin
        check("count", {29'd0, count}, q.size());
        check("empty", {31'd0, empty}, {31'd0, q.size() == 0});
        check("full",  {31'd0, full},  {31'd0, q.size() == DEPTH});
        check("stall", {31'd0, bus.cpu_stall}, {31'd0, bus.cpu_we && (q.size() == DEPTH)});
        if (bus.cpu_re) begin
            check("load_we",    {28'd0, bus.mem_we}, 32'd0);
            check("load_addr",  bus.mem_addr, bus.cpu_addr);
            check("load_rdata", bus.cpu_rdata, exp_load(bus.cpu_addr));
        end else if (q.size() > 0) begin
            check("drain_we",    {28'd0, bus.mem_we}, {28'd0, q[0].strb});
            check("drain_addr",  bus.mem_addr, {q[0].waddr, 2'b00});
            check("drain_wdata", bus.mem_wdata, q[0].data);
        end else begin
            check("idle_we",    {28'd0, bus.mem_we}, 32'd0);
            check("idle_addr",  bus.mem_addr, bus.cpu_addr);
            check("idle_wdata", bus.mem_wdata, 32'd0);
        end
        s_we    = bus.mem_we;
        s_addr  = bus.mem_addr;
        s_wdata = bus.mem_wdata;
        s_valid = 1'b1;
    end

    // data_mem write and model state update at the clock edge
    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        if (rst) begin
            if (s_valid && s_we != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (s_we[i]) mem[s_addr[7:2]][8*i +: 8] = s_wdata[8*i +: 8];
                end
                wlog.push_back(s_addr);
            end
            do_pop  = !bus.cpu_re && (q.size() > 0);
            do_push = bus.cpu_we && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{waddr: bus.cpu_addr[31:2], strb: bus.cpu_wstrb, data: bus.cpu_wdata});
        end
        s_valid = 1'b0;
    end

    // reset discards everything queued
    always @(negedge rst) begin
        q.delete();
        s_valid = 1'b0;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic we, input logic re, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] data);
        bus.cpu_we    = we;
        bus.cpu_re    = re;
        bus.cpu_wstrb = strb;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = data;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;
        mem[8] = 32'h1122_3344;
        idle();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full",  {31'd0, full},  32'd0);
        check("rst_mem_we", {28'd0, bus.mem_we}, 32'd0);
        check("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
        rst = 1'b1;
        tick();

        // three stores, drained one per cycle in order
        drive(1'b1, 1'b0, 4'hF, 32'h10, 32'hA1); tick();
        drive(1'b1, 1'b0, 4'hF, 32'h14, 32'hA2); tick();
        drive(1'b1, 1'b0, 4'hF, 32'h18, 32'hA3); tick();
        idle(); #1;
        check("seq_count", {29'd0, count}, 32'd1);
        check("seq_we",    {28'd0, bus.mem_we}, 32'hF);
        check("seq_addr",  bus.mem_addr, 32'h18);
        tick();
        check("seq_empty", {31'd0, empty}, 32'd1);
        check("seq_mem0", mem[4], 32'hA1);
        check("seq_mem1", mem[5], 32'hA2);
        check("seq_mem2", mem[6], 32'hA3);

        // fill while loads hold the port
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 4'hF, 32'h50 + 4*k, 32'hF0 + k);
            if (k == 4) begin
                #1;
                check("fill_stall", {31'd0, bus.cpu_stall}, 32'd1);
                check("fill_full",  {31'd0, full}, 32'd1);
                check("fill_count", {29'd0, count}, 32'd4);
            end
            tick();
        end
        drive(1'b1, 1'b0, 4'hF, 32'h60, 32'hF4); #1;
        check("fill_stall_hold", {31'd0, bus.cpu_stall}, 32'd1);
        tick();
        check("fill_stall_clear", {31'd0, bus.cpu_stall}, 32'd0);
        check("fill_count3", {29'd0, count}, 32'd3);
        tick();
        idle();
        repeat (3) tick();
        check("fill_empty", {31'd0, empty}, 32'd1);
        check("fill_5th_mem", mem[24], 32'hF4);

        // byte-merge forwarding
        drive(1'b1, 1'b1, 4'b0001, 32'h20, 32'h0000_00AA); tick();
        drive(1'b1, 1'b1, 4'b0011, 32'h20, 32'h0000_BBCC); #1;
        check("fwd_same_cycle", bus.cpu_rdata, 32'h1122_33AA);
        tick();
        drive(1'b0, 1'b1, 4'h0, 32'h20, 32'h0); #1;
        check("fwd_merge", bus.cpu_rdata, 32'h1122_BBCC);
        tick();
        idle();
        repeat (2) tick();
        drive(1'b0, 1'b1, 4'h0, 32'h20, 32'h0); #1;
        check("fwd_from_mem", bus.cpu_rdata, 32'h1122_BBCC);
        check("fwd_mem_word", mem[8], 32'h1122_BBCC);
        tick();

        // load priority
        drive(1'b1, 1'b1, 4'hF, 32'h84, 32'h111); tick();
        drive(1'b1, 1'b1, 4'hF, 32'h88, 32'h222); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 4'h0, 32'hF0, 32'h0); #1;
            check("prio_we", {28'd0, bus.mem_we}, 32'd0);
            tick();
        end
        check("prio_count", {29'd0, count}, 32'd2);
        idle(); #1;
        check("prio_resume_we",   {28'd0, bus.mem_we}, 32'hF);
        check("prio_resume_addr", bus.mem_addr, 32'h84);
        tick();
        tick();

        // asynchronous reset with three stores queued
        drive(1'b1, 1'b1, 4'hF, 32'h40, 32'hD0); tick();
        drive(1'b1, 1'b1, 4'hF, 32'h44, 32'hD1); tick();
        drive(1'b1, 1'b1, 4'hF, 32'h48, 32'hD2); tick();
        idle();
        #2 rst = 1'b0;
        #1;
        check("arst_count", {29'd0, count}, 32'd0);
        check("arst_empty", {31'd0, empty}, 32'd1);
        check("arst_we",    {28'd0, bus.mem_we}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) tick();
        check("arst_mem0", mem[16], 32'hC0DE_0010);
        check("arst_mem1", mem[17], 32'hC0DE_0011);
        check("arst_mem2", mem[18], 32'hC0DE_0012);

        // wrap-around: one in, one out per cycle
        wlog.delete();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 4'hF, 32'h90 + 4*k, 32'h5000 + k); #1;
            check("wrap_count", {29'd0, count}, (k == 0) ? 32'd0 : 32'd1);
            check("wrap_full",  {31'd0, full}, 32'd0);
            tick();
        end
        idle();
        repeat (2) tick();
        check("wrap_nwrites", wlog.size(), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < wlog.size()) check("wrap_order", wlog[k], 32'h90 + 4*k);
        end

        // zero-strobe store occupies a slot but never writes
        drive(1'b1, 1'b0, 4'h0, 32'hC0, 32'hFFFF_FFFF); tick();
        idle(); #1;
        check("zs_count", {29'd0, count}, 32'd1);
        check("zs_we", {28'd0, bus.mem_we}, 32'd0);
        tick();
        check("zs_empty", {31'd0, empty}, 32'd1);
        check("zs_mem", mem[48], 32'hC0DE_0030);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
